// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, sync polarities
// and the line/frame total helpers used for parameter checking.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic SYNC_NEG = 1'b0;
  localparam logic SYNC_POS = 1'b1;

  function automatic int hTotal(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vTotal(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int maxInt(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// Divides the system clock into a one-clk pixel enable; the divider freezes
// whenever en is low so the pixel phase survives a pause.
module vga_pix_ce
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_ce
);

  if (CLK_DIV == 1) begin : gDirect
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst;
    assign pix_ce       = en;
  end else begin : gDiv
    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)    div <= '0;
      else if (en) div <= (div == LAST) ? '0 : div + DW'(1);
    end

    assign pix_ce = en && (div == LAST);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running on the system clock with a pixel enable.
// Define VGA_SNAPSHOT_EN to latch snap_in once per frame; otherwise snap_out passes through.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_NEG,
  parameter logic VS_POL   = SYNC_NEG,
  parameter int   CW       = 11,
  parameter int   SNAP_W   = 176
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SNAP_W-1:0] snap_in,
  output logic              pix_ce,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [CW-1:0]     x,
  output logic [CW-1:0]     y,
  output logic              line_start,
  output logic              frame_start,
  output logic [SNAP_W-1:0] snap_out
);

  localparam int H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CLK_DIV < 1) begin : gBadDiv
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((2 ** CW) < maxInt(H_TOTAL, V_TOTAL)) begin : gBadCw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          pixCe;
  logic [CW-1:0] hCnt;
  logic [CW-1:0] vCnt;

  vga_pix_ce #(.CLK_DIV(CLK_DIV)) uPixCe (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pix_ce(pixCe)
  );

  assign pix_ce = pixCe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixCe) begin
      if (hCnt == H_LAST) begin
        hCnt <= '0;
        vCnt <= (vCnt == V_LAST) ? '0 : vCnt + CW'(1);
      end else begin
        hCnt <= hCnt + CW'(1);
      end
    end
  end

  // Outputs are decoded from the pre-increment counters, so every output
  // lags the counters by exactly one pixel and stays mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixCe) begin
        x           <= hCnt;
        y           <= vCnt;
        de          <= (hCnt < H_ACT) && (vCnt < V_ACT);
        hs          <= (hCnt >= HS_BEG && hCnt < HS_END) ? HS_POL : ~HS_POL;
        vs          <= (vCnt >= VS_BEG && vCnt < VS_END) ? VS_POL : ~VS_POL;
        line_start  <= (hCnt == '0);
        frame_start <= (hCnt == '0) && (vCnt == '0);
      end
    end
  end

`ifdef VGA_SNAPSHOT_EN
  // NOTE: the snapshot register is wide but still reset, so the renderer never sees X before the first frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 snap_out <= '0;
    else if (pixCe && hCnt == '0 && vCnt == '0) snap_out <= snap_in;
  end
`else
  assign snap_out = snap_in;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x480 controller plus its hard-wired divide-by-2 clock.
- Runs on the system clock, not a derived clock. Produces a pixel clock-enable, hsync/vsync, data-enable and pixel coordinates for the renderer.
- Adds frame and line markers, run/freeze control, and a per-frame snapshot of debug data (registers + pc) so the renderer sees a tear-free image.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs
- VS_POL, 0, asserted level of vs
- CW, 11, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- SNAP_W, 176, snapshot width (160 register bits + 16 pc)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low freezes all timing
- snap_in  in  SNAP_W  live debug data
- pix_ce  out  1  one-clk pixel enable
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  active-video flag
- x  out  CW  pixel column
- y  out  CW  pixel row
- line_start  out  1  one-clk pulse, first pixel of each line
- frame_start  out  1  one-clk pulse, first pixel of each frame
- snap_out  out  SNAP_W  frame-stable copy of snap_in

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_ce=1 when div==CLK_DIV-1 and en=1.
  - CLK_DIV=1: pix_ce=en.
- Counters (advance only on clk edges where pix_ce=1):
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 from V_TOTAL-1.
- Output registers load on each pix_ce edge from the pre-increment (h_cnt,v_cnt), giving one pixel of latency, identical for every output:
  - x=h_cnt, y=v_cnt. Raw values, including in blanking.
  - de = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines), else ~VS_POL.
  - line_start=1 if h_cnt==0; frame_start=1 if h_cnt==0 && v_cnt==0. Both forced to 0 on every non-pix_ce clk, so each is exactly one clk wide.
- Reset (async, rst=0):
  - div=0, h_cnt=0, v_cnt=0, x=0, y=0, de=0.
  - hs=~HS_POL, vs=~VS_POL.
  - line_start=0, frame_start=0, snap_out=0.
- After release: the first pix_ce edge outputs (0,0) with line_start=frame_start=1.
- en=0 mid-frame:
  - div, counters and outputs hold; pulses drop to 0.
  - On resume, counting continues from the held position with no extra pulse.
- Reset mid-frame: immediate return to reset values; no partial sync pulse is stretched.
- Elaboration: error if CLK_DIV<1 or if 2**CW < max(H_TOTAL, V_TOTAL).

Optional Feature:
- Macro: VGA_SNAPSHOT_EN.
- Defined: snap_out loads snap_in on the same clk edge that raises frame_start, and holds for the whole frame.
- Undefined: snap_out = snap_in combinational passthrough; no SNAP_W flops.

Decomposition:
- Package vga_pkg:
  - default 640x480@60 timing constants
  - h_total/v_total constant functions
  - sync-polarity constants
- Sub-module vga_pix_ce: CLK_DIV divider with en gating, producing pix_ce.

Test Plan:
- Reset: hold rst=0 → hs=vs=1, de=0, x=y=0, pulses 0; release → first pix_ce outputs (0,0) with frame_start=1.
- Divider, defaults: pix_ce every 2nd clk; line_start period 1600 clks; frame_start period 840000 clks.
- hsync: hs low exactly for x=656..751 (96 pixels = 192 clks); de=1 only for x<640 && y<480.
- vsync: vs low exactly for y=490..491; y wraps 524→0 coincident with frame_start.
- en=0 for 100 clks at (x=300, y=200) → outputs frozen, no pulses; resume → next output x=301.
- Snapshot (VGA_SNAPSHOT_EN): change snap_in mid-frame → snap_out unchanged until next frame_start, then equals snap_in. CLK_DIV=1 variant → pix_ce constantly high.
